// File: rtl/serial_subtractor.sv
// Digit-serial signed two's-complement subtractor, result = A - B.
// Processes DIGIT_WIDTH bits per clock; flags signed overflow.
module serial_subtractor #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow
);

  localparam int N     = DATA_WIDTH / DIGIT_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = DATA_WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if ((DIGIT_WIDTH < 1) || ((DATA_WIDTH % DIGIT_WIDTH) != 0)) begin : g_bad_digit
    $error("serial_subtractor: DIGIT_WIDTH must divide DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    carry_q, carry_d;
  logic [DATA_WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [DATA_WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [DATA_WIDTH-1:0]   res_sh_q, res_sh_d;
  logic                    sign_a_q, sign_a_d;
  logic                    sign_b_q, sign_b_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    overflow_q, overflow_d;

  logic [DIGIT_WIDTH:0]    sum;
  logic [DATA_WIDTH-1:0]   res_next;
  logic                    ovf_next;

  // One digit of A + ~B + carry; low bits are the result digit
  always_comb begin
    sum = {1'b0, a_sh_q[DIGIT_WIDTH-1:0]}
        + {1'b0, b_sh_q[DIGIT_WIDTH-1:0]}
        + (DIGIT_WIDTH+1)'(carry_q);
  end

  if (N == 1) begin : g_one_digit
    // Whole word in one step: the digit is the result
    always_comb res_next = sum[DIGIT_WIDTH-1:0];
  end else begin : g_multi_digit
    // New digit enters the result shifter from the top
    always_comb begin
      res_next = {sum[DIGIT_WIDTH-1:0],
                  res_sh_q[DATA_WIDTH-1:DIGIT_WIDTH]};
    end
  end

  // Signed overflow: operand signs differ and result sign leaves A's
  always_comb begin
    ovf_next = (sign_a_q != sign_b_q) && (res_next[MSB] != sign_a_q);
  end

  // Next-state and datapath update for IDLE / BUSY / DONE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_sh_d   = res_sh_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (in_valid) begin
          a_sh_d   = A;
          b_sh_d   = ~B;
          carry_d  = 1'b1;
          cnt_d    = '0;
          sign_a_d = A[MSB];
          sign_b_d = B[MSB];
          state_d  = BUSY;
        end
      end
      (state_q == BUSY): begin
        carry_d  = sum[DIGIT_WIDTH];
        a_sh_d   = a_sh_q >> DIGIT_WIDTH;
        b_sh_d   = b_sh_q >> DIGIT_WIDTH;
        res_sh_d = res_next;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          result_d   = res_next;
          overflow_d = ovf_next;
          state_d    = DONE;
        end
      end
      (state_q == DONE): begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_sh_q   <= res_sh_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor.
// Driver pushes expectations; monitor pops on output handshake.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   ready_mode = 1;

  serial_subtractor #(
    .DATA_WIDTH (16),
    .DIGIT_WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Consumer: out_ready changes just after the rising edge
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare every accepted output against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      pops++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %h ovf %b expected none",
                 result, overflow);
      end else begin
        e = q.pop_front();
        if (result !== e.res || overflow !== e.ovf) begin
          errors++;
          $display("FAIL result got %h ovf %b expected %h ovf %b",
                   result, overflow, e.res, e.ovf);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    int   sa;
    int   sb;
    int   d;
    exp_t e;
    sa    = int'($signed(a));
    sb    = int'($signed(b));
    d     = sa - sb;
    e.res = d[15:0];
    e.ovf = (d > 32767) || (d < -32768);
    return e;
  endfunction

  // Present one operand pair; returns at the negedge after accept
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic eo);
    int k;
    k = 0;
    @(negedge clk);
    in_valid = 1'b1;
    A = a;
    B = b;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready 0 expected 1");
      in_valid = 1'b0;
    end else begin
      q.push_back('{res: er, ovf: eo});
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_left", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int          lat;
    logic        ir_bad;
    logic        hold_bad;
    int          k;
    int          accepted;
    int          cyc;
    int          pops0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // 1: latency and in_ready low while busy
    ready_mode = 1;
    issue(16'd5, 16'd3, 16'h0002, 1'b0);
    lat    = 0;
    ir_bad = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) ir_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("in_ready_busy", 32'(ir_bad), 32'd0);
    wait_drain(20);

    // 2/3: overflow corners and zero result
    issue(16'h8000, 16'h0001, 16'h7FFF, 1'b1);
    issue(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1);
    issue(16'h1234, 16'h1234, 16'h0000, 1'b0);
    issue(16'h0000, 16'h8000, 16'h8000, 1'b1);
    issue(16'h8000, 16'h7FFF, 16'h0001, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
    issue(16'h0003, 16'h0008, 16'hFFFB, 1'b0);
    wait_drain(40);

    // 4: backpressure hold, ignored operands while DONE
    ready_mode = 0;
    @(negedge clk);
    issue(16'd20, 16'd5, 16'h000F, 1'b0);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("stall_valid", 32'(out_valid), 32'd1);
    hold_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      A = 16'd9;
      B = 16'd0;
      @(negedge clk);
      if (!out_valid || result !== 16'h000F || overflow !== 1'b0)
        hold_bad = 1'b1;
    end
    check("stall_hold", 32'(hold_bad), 32'd0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    in_valid   = 1'b0;
    ready_mode = 1;
    k = 0;
    while (out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("release_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("no_ghost_op", 32'(out_valid), 32'd0);
    wait_drain(5);

    // 5: reset mid-operation aborts
    issue(16'd100, 16'd1, 16'd99, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_result", 32'(result), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(16'd7, 16'd9, 16'hFFFE, 1'b0);
    wait_drain(20);

    // 6: back-to-back random ops with random consumer
    ready_mode = 2;
    accepted   = 0;
    cyc        = 0;
    pops0      = pops;
    @(negedge clk);
    in_valid = 1'b1;
    A = 16'($urandom);
    B = 16'($urandom);
    while (accepted < 1000 && cyc < 40000) begin
      if (in_ready) begin
        q.push_back(model(A, B));
        accepted++;
        @(negedge clk);
        A = 16'($urandom);
        B = 16'($urandom);
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("random_accepted", 32'(accepted), 32'd1000);
    wait_drain(400);
    check("random_pops", 32'(pops - pops0), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
